idct_pix_buf: RTL and testbench

IDCT_PIX_BUF -- requirements
Module: idct_pix_buf

---
 rtl/idct_pix_buf.sv | 148 ++++++++++++++
 tb/tb_idct_pix_buf.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/idct_pix_buf.sv
// Ping-pong transpose buffer between the IDCT row stage and the pixel consumer.
// Column-major signed samples in, level-shifted and clipped 8-bit pixels out in raster order.
module idct_pix_buf #(
  parameter int WIDTH_X   = 16,
  parameter int LVL_SHIFT = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [WIDTH_X-1:0] z_in,
  input  logic                      z_valid,
  output logic [7:0]                pix_out,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      blk_done,
  output logic                      ovf
);

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_FILLING  = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;
  localparam logic [1:0] ST_DRAINING = 2'd3;

  localparam logic signed [WIDTH_X:0] LVL_EXT = (WIDTH_X+1)'(LVL_SHIFT);
  localparam logic signed [WIDTH_X:0] PIX_MAX = (WIDTH_X+1)'(255);

  logic [1:0][1:0] bank_st_q, bank_st_d;
  logic [5:0]      wr_idx_q, wr_idx_d;
  logic            wr_bank_q, wr_bank_d;
  logic [5:0]      rd_idx_q, rd_idx_d;
  logic            rd_bank_q, rd_bank_d;
  logic [7:0]      pix_out_q, pix_out_d;
  logic            pix_valid_q, pix_valid_d;
  logic            out_last_q, out_last_d;
  logic            out_bank_q, out_bank_d;
  logic            blk_done_q, blk_done_d;
  logic            ovf_q, ovf_d;

  logic [7:0]              mem_q [128];
  logic signed [WIDTH_X:0] z_sum;
  logic [7:0]              z_pix;
  logic                    wr_ok, wr_last, rd_start, rd_cont, out_load, out_acc;
  logic [6:0]              wr_addr, rd_addr;

  always_comb begin
    z_sum = {z_in[WIDTH_X-1], z_in} + LVL_EXT;
    if (z_sum[WIDTH_X])       z_pix = 8'd0;
    else if (z_sum > PIX_MAX) z_pix = 8'd255;
    else                      z_pix = z_sum[7:0];
  end

  assign wr_ok   = z_valid && (bank_st_q[wr_bank_q] == ST_EMPTY ||
                               bank_st_q[wr_bank_q] == ST_FILLING);
  assign wr_last = wr_ok && (wr_idx_q == 6'd63);
  // Row/column swap of the column-major index yields the raster address.
  assign wr_addr = {wr_bank_q, wr_idx_q[2:0], wr_idx_q[5:3]};
  assign rd_addr = {rd_bank_q, rd_idx_q};

  // A bank completing its fill this cycle may be selected at once: pixel 0 was
  // written long ago, which gives the single-cycle input-to-output latency.
  assign rd_start = (bank_st_q[rd_bank_q] == ST_FULL) ||
                    (wr_last && (wr_bank_q == rd_bank_q));
  assign rd_cont  = (bank_st_q[rd_bank_q] == ST_DRAINING);
  assign out_load = !pix_valid_q || pix_ready;
  assign out_acc  = pix_valid_q && pix_ready;

  // NOTE: every signal written below gets a default first, so no latch is inferred.
  always_comb begin
    bank_st_d   = bank_st_q;
    wr_idx_d    = wr_idx_q;
    wr_bank_d   = wr_bank_q;
    rd_idx_d    = rd_idx_q;
    rd_bank_d   = rd_bank_q;
    pix_out_d   = pix_out_q;
    pix_valid_d = pix_valid_q;
    out_last_d  = out_last_q;
    out_bank_d  = out_bank_q;
    ovf_d       = ovf_q || (z_valid && !wr_ok);
    blk_done_d  = out_acc && out_last_q;

    if (wr_ok) begin
      wr_idx_d = wr_idx_q + 6'd1;
      if (wr_last) begin
        bank_st_d[wr_bank_q] = ST_FULL;
        wr_bank_d            = ~wr_bank_q;
      end else begin
        bank_st_d[wr_bank_q] = ST_FILLING;
      end
    end

    if (blk_done_d) bank_st_d[out_bank_q] = ST_EMPTY;

    if (out_load) begin
      pix_valid_d = 1'b0;
      out_last_d  = 1'b0;
      if (rd_start || rd_cont) begin
        pix_valid_d          = 1'b1;
        pix_out_d            = mem_q[rd_addr];
        out_last_d           = (rd_idx_q == 6'd63);
        out_bank_d           = rd_bank_q;
        rd_idx_d             = rd_idx_q + 6'd1;
        bank_st_d[rd_bank_q] = ST_DRAINING;
        if (rd_idx_q == 6'd63) rd_bank_d = ~rd_bank_q;
      end
    end
  end

  // NOTE: the pixel store is deliberately left out of reset; every entry is
  // written before it can be read, so a reset would only cost a large mux tree.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_addr] <= z_pix;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st_q   <= '0;
      wr_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      pix_out_q   <= '0;
      pix_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_bank_q  <= 1'b0;
      blk_done_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      bank_st_q   <= bank_st_d;
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      rd_idx_q    <= rd_idx_d;
      rd_bank_q   <= rd_bank_d;
      pix_out_q   <= pix_out_d;
      pix_valid_q <= pix_valid_d;
      out_last_q  <= out_last_d;
      out_bank_q  <= out_bank_d;
      blk_done_q  <= blk_done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign pix_out   = pix_out_q;
  assign pix_valid = pix_valid_q;
  assign blk_done  = blk_done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_idct_pix_buf.sv
// Self-checking bench for idct_pix_buf: directed and random stimulus against a
// block-level model (pixel queue plus count of stored blocks awaiting drain).
module tb_idct_pix_buf;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [15:0] z_in = '0;
  logic              z_valid = 1'b0;
  logic [7:0]        pix_out;
  logic              pix_valid;
  logic              pix_ready = 1'b0;
  logic              blk_done;
  logic              ovf;

  idct_pix_buf #(.WIDTH_X(16), .LVL_SHIFT(128)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .z_in      (z_in),
    .z_valid   (z_valid),
    .pix_out   (pix_out),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .blk_done  (blk_done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int exp_q[$];
  int blk[64];
  int wk;
  int pending;
  int acc_cnt;
  logic ovf_exp;
  logic done_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp_pix(input int z);
    int v;
    v = z + 128;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int rand_z();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 800)) - 400;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    wk = 0;
    pending = 0;
    acc_cnt = 0;
    ovf_exp = 1'b0;
    done_exp = 1'b0;
  endtask

  // Called at posedge+1: compare outputs, drive inputs, advance one clock, update model.
  task automatic step(input logic zv, input int z, input logic rdy);
    logic acc;
    check("pix_valid", pix_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) check("pix_out", pix_out, exp_q[0]);
    check("blk_done", blk_done, done_exp);
    check("ovf", ovf, ovf_exp);
    z_valid   = zv;
    z_in      = z[15:0];
    pix_ready = rdy;
    acc = (exp_q.size() > 0) && rdy;
    @(posedge clk);
    done_exp = 1'b0;
    if (zv) begin
      if (pending < 2) begin
        blk[(wk % 8) * 8 + wk / 8] = clamp_pix(z);
        wk++;
        if (wk == 64) begin
          for (int i = 0; i < 64; i++) exp_q.push_back(blk[i]);
          pending++;
          wk = 0;
        end
      end else begin
        ovf_exp = 1'b1;
      end
    end
    if (acc) begin
      void'(exp_q.pop_front());
      acc_cnt++;
      if (acc_cnt == 64) begin
        acc_cnt = 0;
        pending--;
        done_exp = 1'b1;
      end
    end
    #1;
    z_valid = 1'b0;
  endtask

  task automatic reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_out"}, pix_out, 0);
    check({tag, "_blk_done"}, blk_done, 0);
    check({tag, "_ovf"}, ovf, 0);
    z_valid = 1'b0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input bit rand_rdy);
    int budget;
    budget = 3000;
    while ((exp_q.size() > 0 || done_exp) && budget > 0) begin
      step(1'b0, 0, rand_rdy ? logic'($urandom_range(0, 1)) : 1'b1);
      budget--;
    end
    step(1'b0, 0, 1'b1);
  endtask

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    reset_check("rst0");

    // Ramp block: output is the plain raster transpose 8c+r.
    for (int k = 0; k < 64; k++) step(1'b1, k - 128, 1'b1);
    drain(1'b0);

    // Clipping corners at the head of a block, random fill after.
    begin
      int corner[6] = '{-300, -128, 127, 200, 32767, -32768};
      for (int k = 0; k < 64; k++) step(1'b1, (k < 6) ? corner[k] : rand_z(), 1'b1);
    end
    drain(1'b0);

    // Two blocks back to back, consumer always ready.
    for (int k = 0; k < 128; k++) step(1'b1, rand_z(), 1'b1);
    drain(1'b0);

    // Consumer stalled across three blocks: third block overflows.
    for (int k = 0; k < 192; k++) step(1'b1, rand_z(), 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 0, 1'b0);
    drain(1'b0);

    reset_check("rst1");

    // Random consumer stalls with gapped input.
    for (int k = 0; k < 300; k++)
      step(logic'($urandom_range(0, 3) != 0), rand_z(), logic'($urandom_range(0, 1)));
    drain(1'b1);

    // Reset mid-block, then a clean block must start at its own pixel 0.
    for (int k = 0; k < 30; k++) step(1'b1, rand_z(), 1'b1);
    reset_check("rst2");
    for (int k = 0; k < 64; k++) step(1'b1, rand_z(), 1'b1);
    drain(1'b0);

    // Long random run with overflow pressure.
    for (int k = 0; k < 1500; k++)
      step(logic'($urandom_range(0, 9) < 8), rand_z(), logic'($urandom_range(0, 2) != 0));
    drain(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
